// File: rtl/verify_uart_tx_if.sv
// Programmer-side handshake and host-side status of the verify UART transmitter.
interface verify_uart_tx_if;
  logic        rdy;
  logic        tx_block;
  logic [7:0]  bus_data;
  logic        tx;
  logic        tx_busy;
  logic [11:0] byte_count;
  logic        done;

  modport master (output rdy, tx_block, bus_data,
                  input  tx, tx_busy, byte_count, done);
  modport slave  (input  rdy, tx_block, bus_data,
                  output tx, tx_busy, byte_count, done);
endinterface

// File: rtl/verify_uart_tx.sv
// Captures one EPROM byte per programmer read request and sends it to the host as UART 8N1.
module verify_uart_tx #(
  parameter int CLK_FREQ      = 50000000,
  parameter int BAUD          = 115200,
  parameter int CLKS_PER_BIT  = CLK_FREQ / BAUD,
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_BYTES     = 2048
) (
  input  logic             clk,
  input  logic             rst,
  verify_uart_tx_if.slave  bus
);
  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, START, DATA, STOP, DONE} state_t;

  state_t      state;
  logic        arm;
  logic [SW-1:0] settle_cnt;
  logic [BW-1:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  sr;
  logic        tx_q;
  logic        busy_q;
  logic [11:0] count_q;
  logic        done_q;

  wire bit_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));

  assign bus.tx         = tx_q;
  assign bus.tx_busy    = busy_q;
  assign bus.byte_count = count_q;
  assign bus.done       = done_q;

  // tx is registered from the state, so the line lags the state by one cycle;
  // this gives the extra cycle between the sample edge and the start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      arm        <= 1'b1;
      settle_cnt <= '0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      sr         <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      count_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      // Re-arm whenever the request is withdrawn or inhibited, so one rdy = one frame.
      if (!bus.rdy || bus.tx_block) arm <= 1'b1;

      case (state)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (bus.rdy && !bus.tx_block && arm && !done_q) begin
            busy_q     <= 1'b1;
            arm        <= 1'b0;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            sr       <= bus.bus_data;
            baud_cnt <= '0;
            state    <= START;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        START: begin
          tx_q <= 1'b0;
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          tx_q <= sr[bit_idx];
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            busy_q   <= 1'b0;
            count_q  <= count_q + 12'd1;
            if (count_q + 12'd1 == 12'(NUM_BYTES)) begin
              done_q <= 1'b1;
              state  <= DONE;
            end else begin
              state  <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DONE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_verify_uart_tx.sv
// Directed bench for verify_uart_tx with CLKS_PER_BIT=10, SETTLE_CYCLES=4, NUM_BYTES=4.
module tb_verify_uart_tx;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  verify_uart_tx_if bus();

  verify_uart_tx #(
    .CLK_FREQ(1000), .BAUD(100), .SETTLE_CYCLES(4), .NUM_BYTES(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic exp_tx(input logic [7:0] b, input int k);
    if (k < 5)  return 1'b1;
    if (k < 15) return 1'b0;
    if (k < 95) return b[(k - 15) / 10];
    return 1'b1;
  endfunction

  // Called at a negedge with the DUT idle and armed; acceptance is the next posedge.
  task automatic frame(input logic [7:0] b, input logic [11:0] cnt_exp,
                       input bit pulse, input bit flip, input bit done_exp);
    bus.bus_data = b;
    bus.tx_block = 1'b0;
    bus.rdy      = 1'b1;
    @(negedge clk);
    if (pulse) bus.rdy = 1'b0;
    check("busy_on_accept", bus.tx_busy, 1);
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      check($sformatf("tx_%0h_k%0d", b, k), bus.tx, exp_tx(b, k));
      if (k == 4 && flip) bus.bus_data = 8'hFF;
      if (k == 103) begin
        check("busy_before_end", bus.tx_busy, 1);
        check("done_before_end", bus.done, 0);
      end
      if (k == 104) begin
        check("busy_end", bus.tx_busy, 0);
        check("byte_count", bus.byte_count, cnt_exp);
        check("done", bus.done, done_exp);
      end
    end
  endtask

  task automatic quiet(input int cycles, input string tag);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.tx_busy !== 1'b0 || bus.tx !== 1'b1) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.rdy = 1'b0;
    bus.tx_block = 1'b0;
    bus.bus_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", bus.tx, 1);
    check("rst_busy", bus.tx_busy, 0);
    check("rst_count", bus.byte_count, 0);
    check("rst_done", bus.done, 0);
    rst = 1'b0;
    @(negedge clk);

    // single byte
    frame(8'hA5, 12'd1, 1'b1, 1'b0, 1'b0);

    // held rdy: one frame, then nothing while rdy stays high
    frame(8'hC3, 12'd2, 1'b0, 1'b0, 1'b0);
    quiet(190, "held_rdy_no_retx");
    check("held_count", bus.byte_count, 2);
    bus.rdy = 1'b0;
    @(negedge clk);
    frame(8'h81, 12'd3, 1'b1, 1'b0, 1'b0);

    // tx_block gating
    bus.rdy = 1'b1;
    bus.tx_block = 1'b1;
    quiet(50, "tx_block_gate");
    frame(8'h5E, 12'd4, 1'b1, 1'b0, 1'b1);

    // completed: further requests ignored
    bus.rdy = 1'b1;
    @(negedge clk);
    bus.rdy = 1'b0;
    quiet(120, "done_ignores_rdy");
    check("done_count_hold", bus.byte_count, 4);
    check("done_sticky", bus.done, 1);

    // reset clears done, then mid-frame reset during DATA bit 3
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_done", bus.done, 0);
    check("rst2_count", bus.byte_count, 0);
    bus.bus_data = 8'h96;
    bus.rdy = 1'b1;
    @(negedge clk);
    bus.rdy = 1'b0;
    for (int k = 1; k <= 47; k++) @(negedge clk);
    check("pre_rst_bit3", bus.tx, 0);
    check("pre_rst_busy", bus.tx_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx", bus.tx, 1);
    check("midrst_busy", bus.tx_busy, 0);
    check("midrst_count", bus.byte_count, 0);

    // reset wins over a simultaneous request
    rst = 1'b1;
    bus.rdy = 1'b1;
    @(negedge clk);
    check("rst_req_busy", bus.tx_busy, 0);
    rst = 1'b0;
    bus.rdy = 1'b0;
    @(negedge clk);
    check("rst_req_busy2", bus.tx_busy, 0);

    // full frame after reset; bus changes right after the sample edge
    frame(8'h3C, 12'd1, 1'b1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/verify_uart_tx.md
Name: verify_uart_tx

Overview:
- Downstream consumer of the 8755 programmer during VERIFY.
- When the programmer signals a valid read (rdy high, tx_block low), this block waits for the EPROM data bus to settle and captures the byte.
- It then serialises the byte to the host as UART 8N1, LSB first, and drives tx_busy back to the programmer for the whole frame.
- It counts transmitted bytes and flags completion after a full device image.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer divide), clock cycles per serial bit (derived; may be overridden).
- SETTLE_CYCLES, 4, cycles between accepting a request and sampling bus_data (rd-to-data settle).
- NUM_BYTES, 2048, bytes per verify pass (8755 array size).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rdy  input  1  programmer read-data-valid request.
- tx_block  input  1  programmer inhibit; while high, no new capture starts.
- bus_data  input  8  EPROM AD[7:0] read data.
- tx  output  1  UART serial output, idle high.
- tx_busy  output  1  high from request acceptance until end of stop bit.
- byte_count  output  12  bytes fully transmitted this pass.
- done  output  1  high once byte_count == NUM_BYTES, sticky until rst.

Behaviour:
- Reset (synchronous, active-high), applied at the next clock edge in any state including mid-frame:
  - Outputs: tx=1, tx_busy=0, byte_count=0, done=0.
  - Internal: state=IDLE, arm=1, bit/baud counters=0.
- States are IDLE, SETTLE, START, DATA, STOP, DONE.
- IDLE: tx=1, tx_busy=0.
  - Accept when rdy && !tx_block && arm && !done.
  - On the accepting edge: tx_busy<=1, arm<=0, state<=SETTLE, settle counter<=0.
- Arm rule: arm<=1 on any cycle where rdy==0 or tx_block==1, in any state. This guarantees exactly one transmission per rdy assertion; a continuously high rdy never retransmits.
- SETTLE: counts SETTLE_CYCLES cycles. On the last cycle: shift register<=bus_data, state<=START. Only this sample is used; bus_data changes after that edge are ignored.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; 3-bit bit index wraps 7->0 on exit.
- STOP: tx=1 for CLKS_PER_BIT cycles. On the last stop cycle:
  - byte_count<=byte_count+1, tx_busy<=0.
  - state<=DONE if the new count == NUM_BYTES, else IDLE.
- Frame latency:
  - Accepting edge to tx falling: SETTLE_CYCLES+1 cycles.
  - Accepting edge to tx_busy low: SETTLE_CYCLES + 10*CLKS_PER_BIT cycles.
- DONE: done=1, tx=1, tx_busy=0, all requests ignored, byte_count holds NUM_BYTES. Only rst exits.
- Baud counter width: $clog2(CLKS_PER_BIT+1). It resets to 0 at each bit boundary with no accumulated error; the bit period is exactly CLKS_PER_BIT cycles.
- byte_count is 12 bits so NUM_BYTES=2048 is representable. It never wraps, because DONE blocks further increments.
- rdy dropping or tx_block rising mid-frame does not abort the frame; the block only re-arms.
- Simultaneous rst and request: rst wins, and no frame starts.
- tx is registered, glitch-free, and never low outside START/DATA.

Test Plan:
- Bench settings for all cases: CLK_FREQ=1000, BAUD=100 (CLKS_PER_BIT=10), SETTLE_CYCLES=4, NUM_BYTES=4.
- Single byte:
  - Stimulus: bus_data=8'hA5, pulse rdy=1, tx_block=0.
  - Required: tx_busy high on the next edge; tx low 5 cycles after acceptance; bits 1,0,1,0,0,1,0,1 at 10 cycles each; stop high; tx_busy low 104 cycles after acceptance; byte_count=1.
- Held rdy:
  - Stimulus: rdy held high for 300 cycles.
  - Required: exactly one frame; byte_count=1.
  - Follow-up: drop rdy 1 cycle, then reassert; required: second frame starts, byte_count=2.
- tx_block gating:
  - Stimulus: rdy=1 with tx_block=1 for 50 cycles.
  - Required: tx stays 1, tx_busy stays 0.
  - Follow-up: clear tx_block; required: frame starts on the next edge.
- Bus change after sample:
  - Stimulus: bus_data=8'h3C at the sample edge, changed to 8'hFF 1 cycle later.
  - Required: transmitted byte is 8'h3C.
- Completion:
  - Stimulus: four request/frame cycles.
  - Required: done=1 and byte_count=4 after the 4th stop bit; a 5th rdy pulse produces no frame.
- Mid-frame reset:
  - Stimulus: rst for 1 cycle during DATA bit 3.
  - Required: tx=1, tx_busy=0, byte_count=0 on the following edge; a new rdy pulse yields a full correct frame.
